// File: rtl/rocket_rst_pkg.sv
// Shared types and default constants for the Rocket reset sequencer.
package rocket_rst_pkg;

    // Sequencer states, from power-on calibration wait through ndmreset handling.
    typedef enum logic [2:0] {
        ST_WAIT_CALIB = 3'd0,
        ST_RELEASE    = 3'd1,
        ST_RUN        = 3'd2,
        ST_QUIESCE    = 3'd3,
        ST_HOLD       = 3'd4,
        ST_WAIT_REL   = 3'd5
    } rst_state_e;

    localparam int unsigned DefNumPorts       = 32'd2;
    localparam int unsigned DefCntWidth       = 32'd4;
    localparam int unsigned DefReleaseCycles  = 32'd16;
    localparam int unsigned DefHoldCycles     = 32'd32;
    localparam int unsigned DefQuiesceTimeout = 32'd1024;

    // Largest of three cycle counts; sizes the shared delay/timeout counter.
    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/axi_outstanding_cnt.sv
// Up/down outstanding-transaction counter for one AXI direction of one port.
// Saturates at the top, holds at zero and flags a response seen at zero.
module axi_outstanding_cnt #(
    parameter int unsigned CntWidth = 32'd4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    input  logic                inc,
    input  logic                dec,
    output logic [CntWidth-1:0] cnt,
    output logic                underflow
);

    localparam logic [CntWidth-1:0] CntMax  = {CntWidth{1'b1}};
    localparam logic [CntWidth-1:0] CntZero = {CntWidth{1'b0}};
    localparam logic [CntWidth-1:0] CntOne  = {{(CntWidth-1){1'b0}}, 1'b1};

    logic [CntWidth-1:0] cnt_q;
    logic [CntWidth-1:0] cnt_d;

    // Next count: clear wins, simultaneous inc/dec cancel, saturate at both ends.
    always_comb begin
        cnt_d     = cnt_q;
        underflow = dec & ~inc & (cnt_q == CntZero);
        if (clr) begin
            cnt_d = CntZero;
        end else if (inc && !dec) begin
            cnt_d = (cnt_q == CntMax) ? cnt_q : (cnt_q + CntOne);
        end else if (dec && !inc) begin
            cnt_d = (cnt_q == CntZero) ? cnt_q : (cnt_q - CntOne);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= CntZero;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/rocket_reset_sequencer.sv
// Reset release and debug ndmreset sequencing for the Rocket subsystem.
// Holds the core until DRAM calibrates; on ndreset it blocks and drains the
// AXI ports, then pulses core and peripheral resets.
module rocket_reset_sequencer
    import rocket_rst_pkg::*;
#(
    parameter int unsigned NumPorts       = DefNumPorts,
    parameter int unsigned CntWidth       = DefCntWidth,
    parameter int unsigned ReleaseCycles  = DefReleaseCycles,
    parameter int unsigned HoldCycles     = DefHoldCycles,
    parameter int unsigned QuiesceTimeout = DefQuiesceTimeout
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                dram_calib_done,
    input  logic                debug_ndreset,
    input  logic                debug_dmactive,
    input  logic [NumPorts-1:0] aw_fire,
    input  logic [NumPorts-1:0] b_fire,
    input  logic [NumPorts-1:0] ar_fire,
    input  logic [NumPorts-1:0] r_last_fire,
    output logic                core_rst_n,
    output logic                ndmreset_n,
    output logic                bus_block,
    output logic                seq_busy,
    output logic                timeout_err,
    output logic                proto_err
);

    localparam int unsigned DlyRaw   = $clog2(max3(ReleaseCycles, HoldCycles, QuiesceTimeout));
    localparam int unsigned DlyWidth = (DlyRaw < 32'd1) ? 32'd1 : DlyRaw;
    localparam logic [DlyWidth-1:0] DlyZero  = {DlyWidth{1'b0}};
    localparam logic [DlyWidth-1:0] DlyOne   = {{(DlyWidth-1){1'b0}}, 1'b1};
    localparam logic [DlyWidth-1:0] RelLoad  = DlyWidth'(ReleaseCycles - 32'd1);
    localparam logic [DlyWidth-1:0] HoldLoad = DlyWidth'(HoldCycles - 32'd1);
    localparam logic [DlyWidth-1:0] TmoLast  = DlyWidth'(QuiesceTimeout - 32'd1);

    rst_state_e          state_q, state_d;
    logic [DlyWidth-1:0] dly_q, dly_d;
    logic                ndreset_prev_q;
    logic                core_rst_n_q, core_rst_n_d;
    logic                ndmreset_n_q, ndmreset_n_d;
    logic                bus_block_q, bus_block_d;
    logic                seq_busy_q, seq_busy_d;
    logic                timeout_err_q, timeout_err_d;
    logic                proto_err_q, proto_err_d;

    logic                ndreset_rise_s;
    logic                cnt_clr_s;
    logic                all_idle_s;
    logic [NumPorts-1:0] wr_uf_s, rd_uf_s;
    logic [CntWidth-1:0] wr_cnt_s [NumPorts];
    logic [CntWidth-1:0] rd_cnt_s [NumPorts];

    // debug_dmactive is observed for status only and never gates sequencing.
    logic unused_dmactive_s;
    assign unused_dmactive_s = debug_dmactive;

    assign ndreset_rise_s = debug_ndreset & ~ndreset_prev_q;
    assign cnt_clr_s      = (state_q == ST_HOLD);

    for (genvar p = 0; p < NumPorts; p++) begin : g_port
        axi_outstanding_cnt #(.CntWidth(CntWidth)) u_wr_cnt (
            .clk       (clk),
            .rst_n     (rst_n),
            .clr       (cnt_clr_s),
            .inc       (aw_fire[p]),
            .dec       (b_fire[p]),
            .cnt       (wr_cnt_s[p]),
            .underflow (wr_uf_s[p])
        );
        axi_outstanding_cnt #(.CntWidth(CntWidth)) u_rd_cnt (
            .clk       (clk),
            .rst_n     (rst_n),
            .clr       (cnt_clr_s),
            .inc       (ar_fire[p]),
            .dec       (r_last_fire[p]),
            .cnt       (rd_cnt_s[p]),
            .underflow (rd_uf_s[p])
        );
    end

    // All ports drained when every write and read counter is zero.
    always_comb begin
        all_idle_s = 1'b1;
        for (int p = 0; p < NumPorts; p++) begin
            all_idle_s = all_idle_s & (wr_cnt_s[p] == '0) & (rd_cnt_s[p] == '0);
        end
    end

    // Next-state, shared delay/timeout counter and sticky timeout flag.
    always_comb begin
        state_d       = state_q;
        dly_d         = dly_q;
        timeout_err_d = timeout_err_q;
        case (state_q)
            ST_WAIT_CALIB: begin
                if (dram_calib_done) begin
                    state_d = ST_RELEASE;
                    dly_d   = RelLoad;
                end else begin
                    state_d = ST_WAIT_CALIB;
                end
            end
            ST_RELEASE: begin
                if (!dram_calib_done) begin
                    state_d = ST_WAIT_CALIB;
                end else if (dly_q == DlyZero) begin
                    state_d = ST_RUN;
                end else begin
                    dly_d = dly_q - DlyOne;
                end
            end
            ST_RUN: begin
                if (ndreset_rise_s) begin
                    state_d       = ST_QUIESCE;
                    dly_d         = DlyZero;
                    timeout_err_d = 1'b0;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_QUIESCE: begin
                if (all_idle_s) begin
                    state_d = ST_HOLD;
                    dly_d   = HoldLoad;
                end else if (dly_q == TmoLast) begin
                    state_d       = ST_HOLD;
                    dly_d         = HoldLoad;
                    timeout_err_d = 1'b1;
                end else begin
                    dly_d = dly_q + DlyOne;
                end
            end
            ST_HOLD: begin
                if (dly_q == DlyZero) begin
                    state_d = ST_WAIT_REL;
                end else begin
                    dly_d = dly_q - DlyOne;
                end
            end
            ST_WAIT_REL: begin
                if (!debug_ndreset) begin
                    state_d = ST_RELEASE;
                    dly_d   = RelLoad;
                end else begin
                    state_d = ST_WAIT_REL;
                end
            end
            default: begin
                state_d = ST_WAIT_CALIB;
                dly_d   = DlyZero;
            end
        endcase
    end

    // Output decode from the current state; registered so outputs lag by one cycle.
    always_comb begin
        core_rst_n_d = 1'b0;
        ndmreset_n_d = 1'b0;
        bus_block_d  = 1'b1;
        seq_busy_d   = 1'b1;
        proto_err_d  = proto_err_q | (|wr_uf_s) | (|rd_uf_s);
        case (state_q)
            ST_RELEASE: begin
                ndmreset_n_d = 1'b1;
            end
            ST_RUN: begin
                core_rst_n_d = 1'b1;
                ndmreset_n_d = 1'b1;
                bus_block_d  = 1'b0;
                seq_busy_d   = 1'b0;
            end
            ST_QUIESCE: begin
                core_rst_n_d = 1'b1;
                ndmreset_n_d = 1'b1;
            end
            default: begin
                core_rst_n_d = 1'b0;
                ndmreset_n_d = 1'b0;
            end
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_WAIT_CALIB;
            dly_q          <= DlyZero;
            ndreset_prev_q <= 1'b0;
            core_rst_n_q   <= 1'b0;
            ndmreset_n_q   <= 1'b0;
            bus_block_q    <= 1'b1;
            seq_busy_q     <= 1'b1;
            timeout_err_q  <= 1'b0;
            proto_err_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            dly_q          <= dly_d;
            ndreset_prev_q <= debug_ndreset;
            core_rst_n_q   <= core_rst_n_d;
            ndmreset_n_q   <= ndmreset_n_d;
            bus_block_q    <= bus_block_d;
            seq_busy_q     <= seq_busy_d;
            timeout_err_q  <= timeout_err_d;
            proto_err_q    <= proto_err_d;
        end
    end

    assign core_rst_n  = core_rst_n_q;
    assign ndmreset_n  = ndmreset_n_q;
    assign bus_block   = bus_block_q;
    assign seq_busy    = seq_busy_q;
    assign timeout_err = timeout_err_q;
    assign proto_err   = proto_err_q;

endmodule

// File: tb/tb_rocket_reset_sequencer.sv
// Self-checking bench for rocket_reset_sequencer: directed scenarios followed
// by random traffic, all compared every cycle against a behavioural model.
module tb_rocket_reset_sequencer;

    localparam int NP      = 2;
    localparam int CMAX    = 15;
    localparam int REL_CYC = 16;
    localparam int HOLD_CYC = 32;
    localparam int TMO     = 1024;

    localparam int PH_CAL  = 0;
    localparam int PH_REL  = 1;
    localparam int PH_RUN  = 2;
    localparam int PH_QUI  = 3;
    localparam int PH_HOLD = 4;
    localparam int PH_WREL = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          calib, ndr, dma;
    logic [NP-1:0] aw, b, ar, rl;
    logic          core_rst_n, ndmreset_n, bus_block, seq_busy, timeout_err, proto_err;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int m_ph, m_left, m_wait;
    int m_wr [NP];
    int m_rd [NP];
    bit m_prev, m_terr, m_perr;
    bit e_core, e_ndm, e_blk, e_busy;

    always #5 clk = ~clk;

    rocket_reset_sequencer dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .dram_calib_done (calib),
        .debug_ndreset   (ndr),
        .debug_dmactive  (dma),
        .aw_fire         (aw),
        .b_fire          (b),
        .ar_fire         (ar),
        .r_last_fire     (rl),
        .core_rst_n      (core_rst_n),
        .ndmreset_n      (ndmreset_n),
        .bus_block       (bus_block),
        .seq_busy        (seq_busy),
        .timeout_err     (timeout_err),
        .proto_err       (proto_err)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic void mdl_reset();
        m_ph = PH_CAL; m_left = 0; m_wait = 0;
        for (int p = 0; p < NP; p++) begin m_wr[p] = 0; m_rd[p] = 0; end
        m_prev = 1'b0; m_terr = 1'b0; m_perr = 1'b0;
        e_core = 1'b0; e_ndm = 1'b0; e_blk = 1'b1; e_busy = 1'b1;
    endfunction

    function automatic int cnt_next(input int c, input bit inc, input bit dec, input bit clr);
        if (dec && !inc && c == 0) m_perr = 1'b1;
        if (clr) return 0;
        if (inc && !dec) return (c >= CMAX) ? CMAX : c + 1;
        if (dec && !inc) return (c == 0) ? 0 : c - 1;
        return c;
    endfunction

    // One clock edge of the reference: outputs show the phase held before the edge.
    function automatic void mdl_step();
        bit rise, idle;
        int old_ph;
        rise = ndr && !m_prev;
        idle = 1'b1;
        for (int p = 0; p < NP; p++) if (m_wr[p] != 0 || m_rd[p] != 0) idle = 1'b0;
        old_ph = m_ph;
        e_core = (old_ph == PH_RUN) || (old_ph == PH_QUI);
        e_ndm  = (old_ph == PH_REL) || (old_ph == PH_RUN) || (old_ph == PH_QUI);
        e_blk  = (old_ph != PH_RUN);
        e_busy = (old_ph != PH_RUN);
        if (old_ph == PH_CAL) begin
            if (calib) begin m_ph = PH_REL; m_left = REL_CYC; end
        end else if (old_ph == PH_REL) begin
            if (!calib) m_ph = PH_CAL;
            else begin
                m_left--;
                if (m_left == 0) m_ph = PH_RUN;
            end
        end else if (old_ph == PH_RUN) begin
            if (rise) begin m_ph = PH_QUI; m_terr = 1'b0; m_wait = 0; end
        end else if (old_ph == PH_QUI) begin
            if (idle) begin m_ph = PH_HOLD; m_left = HOLD_CYC; end
            else if (m_wait == TMO - 1) begin m_ph = PH_HOLD; m_left = HOLD_CYC; m_terr = 1'b1; end
            else m_wait++;
        end else if (old_ph == PH_HOLD) begin
            m_left--;
            if (m_left == 0) m_ph = PH_WREL;
        end else begin
            if (!ndr) begin m_ph = PH_REL; m_left = REL_CYC; end
        end
        for (int p = 0; p < NP; p++) begin
            m_wr[p] = cnt_next(m_wr[p], aw[p], b[p], old_ph == PH_HOLD);
            m_rd[p] = cnt_next(m_rd[p], ar[p], rl[p], old_ph == PH_HOLD);
        end
        m_prev = ndr;
    endfunction

    task automatic compare_all();
        check_eq("core_rst_n",  {31'd0, core_rst_n},  {31'd0, e_core});
        check_eq("ndmreset_n",  {31'd0, ndmreset_n},  {31'd0, e_ndm});
        check_eq("bus_block",   {31'd0, bus_block},   {31'd0, e_blk});
        check_eq("seq_busy",    {31'd0, seq_busy},    {31'd0, e_busy});
        check_eq("timeout_err", {31'd0, timeout_err}, {31'd0, m_terr});
        check_eq("proto_err",   {31'd0, proto_err},   {31'd0, m_perr});
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            mdl_step();
            @(negedge clk);
            compare_all();
        end
    endtask

    task automatic fire(input logic [NP-1:0] a_w, input logic [NP-1:0] b_b,
                        input logic [NP-1:0] a_r, input logic [NP-1:0] r_l, input int n);
        aw = a_w; b = b_b; ar = a_r; rl = r_l;
        tick(n);
        aw = '0; b = '0; ar = '0; rl = '0;
    endtask

    initial begin
        rst_n = 1'b0; calib = 1'b0; ndr = 1'b0; dma = 1'b0;
        aw = '0; b = '0; ar = '0; rl = '0;
        mdl_reset();
        repeat (3) @(negedge clk);
        compare_all();
        rst_n = 1'b1;

        // Power-on release after calibration
        tick(5);
        calib = 1'b1;
        tick(25);

        // Calibration drop mid-release, then recalibrate
        rst_n = 1'b0; calib = 1'b0;
        @(negedge clk);
        mdl_reset();
        compare_all();
        rst_n = 1'b1;
        tick(2);
        calib = 1'b1;
        tick(9);
        calib = 1'b0;
        tick(3);
        calib = 1'b1;
        tick(22);

        // Clean ndmreset with outstanding mmio writes and a dram read
        fire(2'b10, 2'b00, 2'b00, 2'b00, 2);
        fire(2'b00, 2'b00, 2'b01, 2'b00, 1);
        ndr = 1'b1;
        tick(4);
        fire(2'b00, 2'b10, 2'b00, 2'b00, 2);
        tick(2);
        fire(2'b00, 2'b00, 2'b00, 2'b01, 1);
        tick(40);
        // Level request held: stays in reset until dropped
        tick(10);
        ndr = 1'b0;
        tick(22);

        // Quiesce timeout with a write that never completes
        fire(2'b01, 2'b00, 2'b00, 2'b00, 1);
        ndr = 1'b1;
        tick(1100);
        ndr = 1'b0;
        tick(22);

        // Simultaneous inc/dec at 3, then saturation, then full drain
        fire(2'b01, 2'b00, 2'b00, 2'b00, 3);
        fire(2'b01, 2'b01, 2'b00, 2'b00, 1);
        fire(2'b01, 2'b00, 2'b00, 2'b00, 20);
        ndr = 1'b1;
        tick(3);
        fire(2'b00, 2'b01, 2'b00, 2'b00, 15);
        tick(40);
        ndr = 1'b0;
        tick(22);

        // Response with nothing outstanding
        fire(2'b00, 2'b10, 2'b00, 2'b00, 1);
        tick(3);

        // Random traffic, calibration glitches and request toggles
        for (int i = 0; i < 3000; i++) begin
            calib = ($urandom_range(0, 63) != 0);
            if ($urandom_range(0, 49) == 0) ndr = ~ndr;
            dma = $urandom_range(0, 1) != 0;
            aw = NP'($urandom & $urandom);
            b  = NP'($urandom & $urandom);
            ar = NP'($urandom & $urandom);
            rl = NP'($urandom & $urandom);
            tick(1);
            if (i == 1500) begin
                #3 rst_n = 1'b0;
                #1 mdl_reset();
                compare_all();
                @(negedge clk);
                compare_all();
                rst_n = 1'b1;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
